// File: rtl/bgsub_frame_ctrl.sv
// Frame sequencer for background subtraction: settles after a capture request, records one
// background frame, then replays the buffer address stream while the mask path is live.
module bgsub_frame_ctrl #(
    parameter int WIDTH         = 800,
    parameter int HEIGHT        = 600,
    parameter int SETTLE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_capture,
    input  logic        VS_negedge,
    input  logic        i_pix_valid,
    output logic        o_dsp_en,
    output logic        o_bg_wr,
    output logic        o_bg_rd,
    output logic [18:0] o_addr,
    output logic        o_mask_en,
    output logic        o_capture_done,
    output logic        o_overrun,
    output logic [2:0]  o_state
);

    localparam logic [18:0] LAST        = 19'(WIDTH * HEIGHT - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_RUN     = 3'd3
    } state_t;

    state_t      state_q, state_d;
    logic [18:0] addr_q, addr_d;
    logic [3:0]  settle_q, settle_d;
    logic        sat_q, sat_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            settle_q <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            mask_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            settle_q <= settle_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            mask_q   <= (state_d == S_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        settle_d = settle_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
        o_dsp_en = 1'b0;
        o_bg_wr  = 1'b0;
        o_bg_rd  = 1'b0;
        o_addr   = VS_negedge ? 19'd0 : addr_q;

        case (state_q)
            S_IDLE: begin
                if (i_capture) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    ovr_d    = 1'b0;
                    addr_d   = '0;
                    sat_d    = 1'b0;
                end
            end
            S_SETTLE: begin
                if (VS_negedge) begin
                    if (settle_q == SETTLE_LAST) begin
                        // This strobe opens the capture frame, so a coincident pixel is stored at 0.
                        state_d  = S_CAPTURE;
                        o_dsp_en = i_pix_valid;
                        o_bg_wr  = i_pix_valid;
                        addr_d   = i_pix_valid ? 19'd1 : 19'd0;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
            end
            S_CAPTURE: begin
                o_dsp_en = i_pix_valid;
                o_bg_wr  = i_pix_valid;
                if (VS_negedge) begin
                    ovr_d  = 1'b1;
                    addr_d = i_pix_valid ? 19'd1 : 19'd0;
                end else if (i_pix_valid) begin
                    if (addr_q == LAST) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        sat_d   = 1'b0;
                    end else begin
                        addr_d = addr_q + 19'd1;
                    end
                end
            end
            S_RUN: begin
                o_dsp_en = i_pix_valid;
                // Once the frame has run past LAST the buffer read is suppressed until the next VS.
                o_bg_rd  = i_pix_valid && (VS_negedge || !sat_q);
                if (i_capture) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    ovr_d    = 1'b0;
                    addr_d   = '0;
                    sat_d    = 1'b0;
                end else if (VS_negedge) begin
                    addr_d = i_pix_valid ? 19'd1 : 19'd0;
                    sat_d  = 1'b0;
                end else if (i_pix_valid) begin
                    if (addr_q == LAST) begin
                        sat_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 19'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_mask_en      = mask_q;
    assign o_capture_done = done_q;
    assign o_overrun      = ovr_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_bgsub_frame_ctrl.sv
// Directed bench for bgsub_frame_ctrl on a reduced 8x4 frame; per-pixel expectations go through a scoreboard queue.
module tb_bgsub_frame_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int LAST = NPIX - 1;

    typedef struct packed {
        logic        ed;
        logic        ew;
        logic        er;
        logic [18:0] ea;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_capture;
    logic        VS_negedge;
    logic        i_pix_valid;
    logic        o_dsp_en;
    logic        o_bg_wr;
    logic        o_bg_rd;
    logic [18:0] o_addr;
    logic        o_mask_en;
    logic        o_capture_done;
    logic        o_overrun;
    logic [2:0]  o_state;

    int compared   = 0;
    int mismatched = 0;
    int wr_cnt     = 0;
    int rd_cnt     = 0;
    exp_t sb[$];

    bgsub_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .SETTLE_FRAMES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_capture      (i_capture),
        .VS_negedge     (VS_negedge),
        .i_pix_valid    (i_pix_valid),
        .o_dsp_en       (o_dsp_en),
        .o_bg_wr        (o_bg_wr),
        .o_bg_rd        (o_bg_rd),
        .o_addr         (o_addr),
        .o_mask_en      (o_mask_en),
        .o_capture_done (o_capture_done),
        .o_overrun      (o_overrun),
        .o_state        (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic regs(input string tag, input logic [2:0] st, input logic mk, input logic dn, input logic ov);
        chk(tag, {26'd0, o_state, o_mask_en, o_capture_done, o_overrun}, {26'd0, st, mk, dn, ov});
    endtask

    // One clock: drive at negedge, check combinational strobes 1ns later, return 1ns after the posedge.
    task automatic step(input bit c, input bit v, input bit p,
                        input bit ed, input bit ew, input bit er, input int ea);
        exp_t e;
        @(negedge clk);
        i_capture   = c;
        VS_negedge  = v;
        i_pix_valid = p;
        if (p) sb.push_back('{ed: ed, ew: ew, er: er, ea: 19'(ea)});
        #1;
        if (p) begin
            e = sb.pop_front();
            chk("pix", {10'd0, o_dsp_en, o_bg_wr, o_bg_rd, o_addr}, {10'd0, e.ed, e.ew, e.er, e.ea});
        end else begin
            chk("nopix", {29'd0, o_dsp_en, o_bg_wr, o_bg_rd}, 32'd0);
        end
        if (o_bg_wr) wr_cnt++;
        if (o_bg_rd) rd_cnt++;
        @(posedge clk);
        #1;
        i_capture   = 1'b0;
        VS_negedge  = 1'b0;
        i_pix_valid = 1'b0;
    endtask

    task automatic vs_only();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic cap_pixels(input int start, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, start + i);
    endtask

    task automatic settle_to_capture();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            vs_only();
            regs("settle_count", (k < 3) ? 3'd1 : 3'd2, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_capture   = 1'b0;
        VS_negedge  = 1'b0;
        i_pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        regs("reset_regs", 3'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_outs", {10'd0, o_dsp_en, o_bg_wr, o_bg_rd, o_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Raw video: three frames with no capture request.
        repeat (3) begin
            vs_only();
            for (int i = 0; i < NPIX; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end
        regs("idle_regs", 3'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_strobes", 32'(wr_cnt + rd_cnt), 32'd0);

        // First clean capture.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        regs("settle_enter", 3'd1, 1'b0, 1'b0, 1'b0);
        settle_to_capture();
        wr_cnt = 0;
        cap_pixels(0, NPIX - 1);
        regs("cap_before_last", 3'd2, 1'b0, 1'b0, 1'b0);
        cap_pixels(LAST, 1);
        regs("cap_done", 3'd3, 1'b1, 1'b1, 1'b0);
        chk("wr_count", 32'(wr_cnt), 32'(NPIX));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        regs("done_one_cycle", 3'd3, 1'b1, 1'b0, 1'b0);

        // Run: VS coincident with a valid, then saturation past LAST.
        rd_cnt = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 1; i < NPIX; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, i);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LAST);
        chk("rd_count", 32'(rd_cnt), 32'(NPIX));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        regs("run_regs", 3'd3, 1'b1, 1'b0, 1'b0);

        // Recapture with a short frame.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        regs("recap_enter", 3'd1, 1'b0, 1'b0, 1'b0);
        settle_to_capture();
        cap_pixels(0, 10);
        vs_only();
        regs("overrun", 3'd2, 1'b0, 1'b0, 1'b1);
        wr_cnt = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        regs("cap_ignores_capture", 3'd2, 1'b0, 1'b0, 1'b1);
        cap_pixels(1, NPIX - 1);
        regs("overrun_done", 3'd3, 1'b1, 1'b1, 1'b1);
        chk("wr_count_after_overrun", 32'(wr_cnt), 32'(NPIX));

        // Capture request wins over a coincident frame strobe.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        regs("cap_vs_coincident", 3'd1, 1'b0, 1'b0, 1'b0);
        settle_to_capture();
        cap_pixels(0, 5);
        regs("mid_capture", 3'd2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-capture.
        rst_n = 1'b0;
        #1;
        regs("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        regs("after_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
